// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter/sequencer for a shared combinational ALU.
// Optional instruction legality check: define ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter logic [31:0] IDLE_INSTR = 32'h0000_0020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_instr,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req1_instr,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic [31:0] alu_instruction,
  output logic [31:0] alu_regA,
  output logic [31:0] alu_regB,
  input  logic [31:0] alu_result,
  input  logic [2:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [2:0]  rsp_flags,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t      r_state, w_next;
  logic        r_last_grant;
  logic [31:0] r_instr, r_a, r_b;
  logic        r_id, r_legal;
  logic [31:0] r_rsp_result;
  logic [2:0]  r_rsp_flags;
  logic        r_rsp_id;

  logic        w_grant, w_accept, w_legal;
  logic [31:0] w_in_instr, w_in_a, w_in_b;

`ifdef ALU_ARB_OPCHECK_EN
  function automatic logic f_legal(input logic [31:0] instr);
    logic ok;
    ok = 1'b0;
    case (instr[31:26])
      6'h00: begin
        case (instr[5:0])
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
          6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: ok = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      6'h04, 6'h05, 6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h2B: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction
`endif

  // Single valid port wins outright; on contention the port not granted last time wins.
  always_comb begin
    case (req_valid)
      2'b10:   w_grant = 1'b1;
      2'b11:   w_grant = ~r_last_grant;
      default: w_grant = 1'b0;
    endcase
  end

  assign w_in_instr = w_grant ? req1_instr : req0_instr;
  assign w_in_a     = w_grant ? req1_a     : req0_a;
  assign w_in_b     = w_grant ? req1_b     : req0_b;

`ifdef ALU_ARB_OPCHECK_EN
  assign w_legal = f_legal(w_in_instr);
`else
  assign w_legal = 1'b1;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_next    = r_state;
    req_ready = 2'b00;
    w_accept  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && (req_valid != 2'b00)) begin
          req_ready = w_grant ? 2'b10 : 2'b01;
          w_accept  = 1'b1;
          w_next    = S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= 1'b1;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
      r_rsp_id     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) r_last_grant <= w_grant;
      if (r_state == S_ISSUE) begin
        r_rsp_result <= r_legal ? alu_result : '0;
        r_rsp_flags  <= r_legal ? alu_flags  : '0;
        r_rsp_id     <= r_id;
      end
    end
  end

  // NOTE: issue registers are pure datapath, always written before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_instr <= w_in_instr;
      r_a     <= w_in_a;
      r_b     <= w_in_b;
      r_id    <= w_grant;
      r_legal <= w_legal;
    end
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic r_rsp_err;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_rsp_err <= 1'b0;
    else if (r_state == S_ISSUE) r_rsp_err <= ~r_legal;
  end
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  // Illegal instructions never reach the ALU; it keeps seeing the benign idle encoding.
  assign alu_instruction = (r_state == S_ISSUE && r_legal) ? r_instr : IDLE_INSTR;
  assign alu_regA        = (r_state == S_ISSUE && r_legal) ? r_a     : '0;
  assign alu_regB        = (r_state == S_ISSUE && r_legal) ? r_b     : '0;

  assign rsp_valid  = (r_state == S_RESP);
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
  assign busy       = (r_state != S_IDLE);

endmodule
